// File: rtl/chebyshev_step_controller_pkg.sv
// Shared definitions for the Chebyshev recursion step controller:
// default parameter values, state encodings and the state enum type.
package chebyshev_step_controller_pkg;

  localparam int CHEB_ITER_WIDTH   = 8;
  localparam int CHEB_MAX_ITER     = 16;
  localparam int CHEB_STEP_LATENCY = 3;

  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_LOAD_ENC   = 3'd1;
  localparam logic [2:0] ST_STEP_ENC   = 3'd2;
  localparam logic [2:0] ST_WAIT_ENC   = 3'd3;
  localparam logic [2:0] ST_COMMIT_ENC = 3'd4;
  localparam logic [2:0] ST_DONE_ENC   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_LOAD   = ST_LOAD_ENC,
    ST_STEP   = ST_STEP_ENC,
    ST_WAIT   = ST_WAIT_ENC,
    ST_COMMIT = ST_COMMIT_ENC,
    ST_DONE   = ST_DONE_ENC
  } state_e;

endpackage

// File: rtl/chebyshev_step_controller_timer.sv
// Loadable/clearable up-counter with a terminal flag. The controller clears
// it when a step is launched and lets it count through the pipeline wait.
module chebyshev_latency_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] terminal_value_i,
  output logic [WIDTH-1:0] count_o,
  output logic             terminal_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Clear wins over load, load wins over counting.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_value_i;
    end else if (enable_i) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o    = count_q;
  assign terminal_o = (count_q == terminal_value_i);

endmodule

// File: rtl/chebyshev_step_controller.sv
// Sequencing controller for the Chebyshev recursion datapath
// (T(k+1) = 2x*T(k) - T(k-1)). Owns all datapath enables: initial load,
// per-iteration step launch, pipeline wait, and commit/shift.
// Optional feature macro: CHEB_EARLY_STOP_EN (convergence-based early stop,
// adds the converged input and done_early output).
module chebyshev_step_controller
  import chebyshev_step_controller_pkg::*;
#(
  parameter int ITER_WIDTH   = CHEB_ITER_WIDTH,
  parameter int MAX_ITER     = CHEB_MAX_ITER,
  parameter int STEP_LATENCY = CHEB_STEP_LATENCY
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ITER_WIDTH-1:0] n_iter,
  output logic                  busy,
  output logic                  load_init,
  output logic                  step_en,
  output logic                  shift_en,
  output logic [ITER_WIDTH-1:0] iter_idx,
  output logic                  done
`ifdef CHEB_EARLY_STOP_EN
  ,
  input  logic                  converged,
  output logic                  done_early
`endif
);

  // The timer only needs to reach STEP_LATENCY-2 (last WAIT cycle).
  localparam int TW = (STEP_LATENCY > 1) ? $clog2(STEP_LATENCY) : 1;
  localparam logic [TW-1:0] LAT_TERM = TW'((STEP_LATENCY >= 2) ? (STEP_LATENCY - 2) : 0);
  localparam logic [ITER_WIDTH-1:0] MAX_N = ITER_WIDTH'(MAX_ITER);

  state_e state_q, state_d;
  logic [ITER_WIDTH-1:0] n_eff_q, n_eff_d;
  logic [ITER_WIDTH-1:0] iter_q, iter_d;
  logic [ITER_WIDTH-1:0] iter_inc;
  logic                  timer_clear;
  logic                  timer_en;
  logic                  timer_terminal;
  logic [TW-1:0]         timer_count;
  logic                  busy_q, load_q, step_q, shift_q, done_q;
`ifdef CHEB_EARLY_STOP_EN
  logic                  early_d;
  logic                  done_early_q;
`endif

  chebyshev_latency_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clock            (clock),
    .resetn           (resetn),
    .clear_i          (timer_clear),
    .load_i           (1'b0),
    .load_value_i     ('0),
    .enable_i         (timer_en),
    .terminal_value_i (LAT_TERM),
    .count_o          (timer_count),
    .terminal_o       (timer_terminal)
  );

  // Next-state, capture, iteration-index and timer-control decode.
  always_comb begin
    state_d     = state_q;
    n_eff_d     = n_eff_q;
    iter_d      = iter_q;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    iter_inc    = iter_q + ITER_WIDTH'(1);
`ifdef CHEB_EARLY_STOP_EN
    early_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          n_eff_d = (n_iter > MAX_N) ? MAX_N : n_iter;
          iter_d  = '0;
        end
      end
      ST_LOAD: begin
        state_d = (n_eff_q == '0) ? ST_DONE : ST_STEP;
      end
      ST_STEP: begin
        if (STEP_LATENCY == 1) begin
          state_d = ST_COMMIT;
        end else begin
          state_d     = ST_WAIT;
          timer_clear = 1'b1;
        end
      end
      ST_WAIT: begin
        timer_en = 1'b1;
        if (timer_terminal) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        iter_d = iter_inc;
        if (iter_inc == n_eff_q) begin
          state_d = ST_DONE;
`ifdef CHEB_EARLY_STOP_EN
        end else if (converged && (iter_inc < n_eff_q)) begin
          state_d = ST_DONE;
          early_d = 1'b1;
`endif
        end else begin
          state_d = ST_STEP;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, captured count, index and registered output decode of the next state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      n_eff_q      <= '0;
      iter_q       <= '0;
      busy_q       <= 1'b0;
      load_q       <= 1'b0;
      step_q       <= 1'b0;
      shift_q      <= 1'b0;
      done_q       <= 1'b0;
`ifdef CHEB_EARLY_STOP_EN
      done_early_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      n_eff_q      <= n_eff_d;
      iter_q       <= iter_d;
      busy_q       <= (state_d != ST_IDLE);
      load_q       <= (state_d == ST_LOAD);
      step_q       <= (state_d == ST_STEP);
      shift_q      <= (state_d == ST_COMMIT);
      done_q       <= (state_d == ST_DONE);
`ifdef CHEB_EARLY_STOP_EN
      done_early_q <= early_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign load_init = load_q;
  assign step_en   = step_q;
  assign shift_en  = shift_q;
  assign done      = done_q;
  assign iter_idx  = iter_q;
`ifdef CHEB_EARLY_STOP_EN
  assign done_early = done_early_q;
`endif

endmodule

// File: tb/tb_chebyshev_step_controller.sv
// Scoreboard testbench for chebyshev_step_controller. Each run's pulse
// sequence is derived from the cycle formulas and queued; a negedge monitor
// pops and compares whenever the DUT raises a pulse.
module tb_chebyshev_step_controller;

  localparam int W    = 8;
  localparam int MAXN = 16;
  localparam int L    = 3;

  logic         clock  = 1'b0;
  logic         resetn = 1'b0;
  logic         start  = 1'b0;
  logic [W-1:0] n_iter = '0;
  logic         busy, load_init, step_en, shift_en, done;
  logic [W-1:0] iter_idx;
`ifdef CHEB_EARLY_STOP_EN
  logic         converged = 1'b0;
  logic         done_early;
`endif

  chebyshev_step_controller #(
    .ITER_WIDTH   (W),
    .MAX_ITER     (MAXN),
    .STEP_LATENCY (L)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .n_iter     (n_iter),
    .busy       (busy),
    .load_init  (load_init),
    .step_en    (step_en),
    .shift_en   (shift_en),
    .iter_idx   (iter_idx),
    .done       (done)
`ifdef CHEB_EARLY_STOP_EN
    ,
    .converged  (converged),
    .done_early (done_early)
`endif
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Cycle number: the period following posedge p is cycle p.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  localparam logic [3:0] K_LOAD  = 4'b0001;
  localparam logic [3:0] K_STEP  = 4'b0010;
  localparam logic [3:0] K_SHIFT = 4'b0100;
  localparam logic [3:0] K_DONE  = 4'b1000;

  typedef struct {
    int         cyc;
    logic [3:0] kind;
    int         idx;
    bit         early;
  } expEvt_t;

  expEvt_t expQ[$];
  expEvt_t monE;
  logic [3:0] monPulses;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: actual %0d required %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference model: expected pulse sequence of one run whose start is sampled at the end of cycle c0.
  function automatic void pushRun(input int c0, input int nReq, input int convAt,
                                  output int doneCyc, output int stopN);
    int  nEff;
    bit  early;
    expEvt_t e;
    nEff  = (nReq > MAXN) ? MAXN : nReq;
    stopN = nEff;
    early = 1'b0;
    if (convAt >= 0 && convAt + 1 < nEff) begin
      stopN = convAt + 1;
      early = 1'b1;
    end
    e.cyc = c0 + 1; e.kind = K_LOAD; e.idx = 0; e.early = 1'b0;
    expQ.push_back(e);
    for (int k = 0; k < stopN; k++) begin
      e.cyc = c0 + 2 + k * (L + 1); e.kind = K_STEP; e.idx = k;
      expQ.push_back(e);
      e.cyc = c0 + 2 + k * (L + 1) + L; e.kind = K_SHIFT; e.idx = k;
      expQ.push_back(e);
    end
    doneCyc = c0 + 2 + stopN * (L + 1);
    e.cyc = doneCyc; e.kind = K_DONE; e.idx = stopN; e.early = early;
    expQ.push_back(e);
  endfunction

  // Monitor: flags missed events, unexpected pulses, and compares popped events.
  always @(negedge clock) begin
    if (resetn) begin
      monPulses = {done, shift_en, step_en, load_init};
      while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
        checkOutput("missed_event_cycle", cyc, expQ[0].cyc);
        void'(expQ.pop_front());
      end
      if (monPulses != 4'b0000) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_pulse", int'(monPulses), 0);
        end else begin
          monE = expQ.pop_front();
          checkOutput("pulse_kind", int'(monPulses), int'(monE.kind));
          checkOutput("pulse_cycle", cyc, monE.cyc);
          checkOutput("pulse_iter_idx", int'(iter_idx), monE.idx);
          checkOutput("pulse_busy", int'(busy), 1);
`ifdef CHEB_EARLY_STOP_EN
          if (monE.kind == K_DONE) checkOutput("done_early", int'(done_early), int'(monE.early));
`endif
        end
      end
`ifdef CHEB_EARLY_STOP_EN
      if (done_early && !done) checkOutput("done_early_without_done", 1, 0);
`endif
    end
  end

  // Launch one run in the current (IDLE) cycle.
  task automatic applyStimulus(input int nReq, input int convAt,
                               output int c0, output int doneCyc, output int stopN);
    start  = 1'b1;
    n_iter = W'(nReq);
    c0     = cyc;
    pushRun(c0, nReq, convAt, doneCyc, stopN);
    @(posedge clock); #1;
    start  = 1'b0;
    n_iter = W'($urandom);
  endtask

  // Drive the run until done has passed, then check the idle state.
  task automatic waitRun(input int c0, input int doneCyc, input int convAt,
                         input int stopN, input bit spurious);
    int rel;
    while (cyc <= doneCyc) begin
      start  = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      n_iter = W'($urandom);
`ifdef CHEB_EARLY_STOP_EN
      rel = cyc - c0 - 2 - L;
      if (rel >= 0 && (rel % (L + 1)) == 0) converged = (rel / (L + 1) == convAt);
      else converged = 1'($urandom_range(0, 1));
`else
      rel = convAt;
`endif
      @(posedge clock); #1;
    end
    start = 1'b0;
`ifdef CHEB_EARLY_STOP_EN
    converged = 1'b0;
`endif
    checkOutput("queue_drained", expQ.size(), 0);
    expQ.delete();
    checkOutput("busy_after_done", int'(busy), 0);
    checkOutput("iter_idx_hold", int'(iter_idx), stopN);
  endtask

  initial begin
    int c0, d, s, c1, d2, s2, target, nReq, convAt;

    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_load_init", int'(load_init), 0);
    checkOutput("reset_step_en", int'(step_en), 0);
    checkOutput("reset_shift_en", int'(shift_en), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_iter_idx", int'(iter_idx), 0);
    resetn = 1'b1;
    @(posedge clock); #1;

    // Basic run, then n=0, then clamp.
    applyStimulus(4, -1, c0, d, s);
    checkOutput("basic_done_offset", d - c0, 18);
    waitRun(c0, d, -1, s, 1'b0);
    applyStimulus(0, -1, c0, d, s);
    waitRun(c0, d, -1, s, 1'b0);
    applyStimulus(200, -1, c0, d, s);
    waitRun(c0, d, -1, s, 1'b1);

    // Start held high through a 2-iteration run: second run starts after DONE.
    start  = 1'b1;
    n_iter = W'(2);
    c0     = cyc;
    pushRun(c0, 2, -1, d, s);
    @(posedge clock); #1;
    n_iter = W'(1);
    c1 = d + 1;
    pushRun(c1, 1, -1, d2, s2);
    while (cyc < c1) begin
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    start = 1'b0;
    waitRun(c1, d2, -1, s2, 1'b0);

    // Reset during the WAIT of iteration 2.
    applyStimulus(5, -1, c0, d, s);
    target = c0 + 2 + 2 * (L + 1) + 1;
    while (cyc < target) begin
      @(posedge clock); #1;
    end
    checkOutput("pre_reset_iter_idx", int'(iter_idx), 2);
    resetn = 1'b0;
    #1;
    expQ.delete();
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_step_en", int'(step_en), 0);
    checkOutput("midreset_shift_en", int'(shift_en), 0);
    checkOutput("midreset_done", int'(done), 0);
    checkOutput("midreset_iter_idx", int'(iter_idx), 0);
    @(posedge clock); #1;
    resetn = 1'b1;
    repeat (4) begin
      @(posedge clock); #1;
    end
    checkOutput("post_reset_busy", int'(busy), 0);

`ifdef CHEB_EARLY_STOP_EN
    applyStimulus(8, 2, c0, d, s);
    checkOutput("early_stop_count", s, 3);
    waitRun(c0, d, 2, s, 1'b0);
    applyStimulus(4, 3, c0, d, s);
    waitRun(c0, d, 3, s, 1'b0);
`endif

    // Randomized runs with random gaps (zero gap = earliest restart).
    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(0, 9))
        0:       nReq = 0;
        1:       nReq = 200 + int'($urandom_range(0, 55));
        default: nReq = int'($urandom_range(1, 20));
      endcase
      convAt = -1;
`ifdef CHEB_EARLY_STOP_EN
      if ($urandom_range(0, 2) == 0) convAt = int'($urandom_range(0, 19));
`endif
      applyStimulus(nReq, convAt, c0, d, s);
      waitRun(c0, d, convAt, s, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock); #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/chebyshev_step_controller.md
# chebyshev_step_controller

Sequencing controller for the Chebyshev recursion datapath (T(k+1) = 2x·T(k) − T(k−1)). It accepts a start request with a runtime iteration count, loads the initial terms, then issues one step per iteration. Each step is followed by a fixed-latency wait for the multiply/subtract pipeline and a commit pulse that shifts the term registers. It reports progress through an iteration index and finishes with a one-cycle done pulse. It sits between the top-level command logic and the recursion datapath, and owns all datapath enables.

## Interface
- ITER_WIDTH, 8: width of iteration count and index.
- MAX_ITER, 16: hard upper bound on iterations; must be ≤ 2^ITER_WIDTH − 1.
- STEP_LATENCY, 3: datapath cycles from step_en to valid result; must be ≥ 1.

- clock  in  1  system clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- n_iter  in  ITER_WIDTH  requested iterations; captured with start.
- busy  out  1  high in every state except IDLE; reset 0.
- load_init  out  1  one-cycle pulse: datapath loads T0 = 1, T1 = x; reset 0.
- step_en  out  1  one-cycle pulse launching one recursion step; reset 0.
- shift_en  out  1  one-cycle pulse committing the result (T(k−1) ← T(k), T(k) ← result); reset 0.
- iter_idx  out  ITER_WIDTH  completed iterations of the current or last run; reset 0.
- done  out  1  one-cycle completion pulse; reset 0.
- converged  in  1  datapath convergence flag (CHEB_EARLY_STOP_EN only).
- done_early  out  1  pulses with done when the run ended on convergence; reset 0 (CHEB_EARLY_STOP_EN only).

## Operation
- FSM states: IDLE, LOAD, STEP, WAIT, COMMIT, DONE. The reset state is IDLE. All outputs are registered and decoded from the state.
- IDLE → LOAD when start = 1. The block captures n_eff = min(n_iter, MAX_ITER) into an internal register.
- LOAD: load_init = 1 and iter_idx is cleared to 0. If n_eff = 0, the next state is DONE; otherwise it is STEP.
- STEP: step_en = 1. If STEP_LATENCY = 1, the next state is COMMIT; otherwise it is WAIT, with the latency counter cleared.
- WAIT: the latency counter counts up. The FSM leaves for COMMIT after STEP_LATENCY − 1 WAIT cycles.
- COMMIT: shift_en = 1 and iter_idx increments. If the new iter_idx equals n_eff, the next state is DONE; otherwise it is STEP.
- DONE: done = 1 for one cycle, then the FSM returns to IDLE. iter_idx holds its value until the next LOAD.
- Ignored inputs:
  - start outside IDLE is ignored; no queuing.
  - n_iter changes after capture are ignored.
- Arithmetic: the comparison uses the full ITER_WIDTH. The clamp is unsigned. iter_idx never exceeds n_eff, so it never wraps.
- Reset mid-run: all outputs drop to their reset values immediately (asynchronous), the FSM returns to IDLE, and no done pulse is generated.

## Timing
- Cycle 0 is the edge where start is sampled in IDLE. LOAD is cycle 1.
- Iteration k (k = 0..n_eff−1) occupies STEP_LATENCY + 1 cycles:
  - step_en in cycle 2 + k·(STEP_LATENCY+1);
  - shift_en in cycle 2 + k·(STEP_LATENCY+1) + STEP_LATENCY.
- done is high in cycle 2 + n_eff·(STEP_LATENCY+1). With n_eff = 0, done is high in cycle 2.
- The earliest restart is a start sampled in the cycle after DONE.
- load_init, step_en, shift_en and done are mutually exclusive in every cycle.

## Configuration
- Macro: CHEB_EARLY_STOP_EN.
- Defined:
  - converged is sampled in COMMIT. If it is 1 and iter_idx + 1 < n_eff, the next state is DONE.
  - done_early pulses together with done. iter_idx shows the iterations actually completed.
  - Convergence on the final commit does not set done_early.
- Undefined: the converged and done_early ports are absent, and the run always completes n_eff iterations.

## Structure
- A shared package holds:
  - the state enum type;
  - the encoding constants for IDLE/LOAD/STEP/WAIT/COMMIT/DONE;
  - the default ITER_WIDTH, MAX_ITER and STEP_LATENCY values.
- Sub-module: chebyshev_latency_timer, a loadable/clearable up-counter with a terminal flag, used for the WAIT countdown. The iteration index stays in the top module.

## Test plan
- Basic run, STEP_LATENCY = 3: reset, then start with n_iter = 4.
  - load_init in cycle 1.
  - step_en in cycles 2, 6, 10, 14; shift_en in cycles 5, 9, 13, 17.
  - done in cycle 18; iter_idx = 4 afterwards.
- n_iter = 0 → load_init in cycle 1, done in cycle 2, no step_en or shift_en, iter_idx = 0.
- Clamp: n_iter = 200 with MAX_ITER = 16 → exactly 16 shift_en pulses, then done with iter_idx = 16.
- Spurious start: start held high throughout a 2-iteration run → one run only; a new LOAD occurs only in the cycle after the start sampled post-DONE.
- Reset mid-run: resetn low during WAIT of iteration 2 → outputs are 0 and iter_idx = 0 immediately, no done, FSM in IDLE.
- Early stop (CHEB_EARLY_STOP_EN): n_iter = 8, converged = 1 at the third COMMIT → done and done_early together in the next cycle, iter_idx = 3.
